// File: rtl/dds_reg_arbiter_if.sv
// -----------------------------------------------------------------------------
// dds_reg_arbiter_if
// Bundle of everything the register-access arbiter talks to: the two
// requester ports (instruction controller on port 0, host/debug loader on
// port 1) and the single wr_cmd serial register engine behind it.
//
//   Requester side : req0/1, addr0/1, din0/1   -> arbiter
//                    done0/1, err0/1, rdata, busy, gnt_id <- arbiter
//   wr_cmd side    : wr_start, wr_addr, wr_din  <- arbiter
//                    wr_done, wr_dout           -> arbiter
//
// slave  : the arbiter's view (serves requests, owns the wr_cmd outputs)
// master : the environment's view (requesters plus wr_cmd engine)
// -----------------------------------------------------------------------------
interface dds_reg_arbiter_if;
    // requester ports
    logic        req0;
    logic        req1;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        done0;
    logic        done1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata;
    logic        busy;
    logic        gnt_id;
    // wr_cmd engine
    logic        wr_start;
    logic [7:0]  wr_addr;
    logic [31:0] wr_din;
    logic        wr_done;
    logic [31:0] wr_dout;

    modport slave (
        input  req0, req1, addr0, addr1, din0, din1, wr_done, wr_dout,
        output done0, done1, err0, err1, rdata, busy, gnt_id,
               wr_start, wr_addr, wr_din
    );

    modport master (
        output req0, req1, addr0, addr1, din0, din1, wr_done, wr_dout,
        input  done0, done1, err0, err1, rdata, busy, gnt_id,
               wr_start, wr_addr, wr_din
    );
endinterface

// File: rtl/dds_reg_arbiter.sv
// -----------------------------------------------------------------------------
// dds_reg_arbiter
// Shares one DDS serial register-access engine (wr_cmd) between two
// requesters with round-robin arbitration, one transaction at a time.
// Address/data are captured at grant and held stable toward wr_cmd for the
// whole transaction; a WAIT-phase timeout aborts a transaction whose
// wr_done never arrives. The result and a one-cycle done pulse go back to
// the winning port only. All outputs are registered.
//
// Ports
//   clk  in  system clock, posedge
//   rst  in  asynchronous reset, active low
//   bus  dds_reg_arbiter_if.slave (requester ports + wr_cmd handshake)
//
// Parameters
//   TIMEOUT  WAIT cycles allowed before abort (>= 2)
//   CNT_W    counter width, must hold TIMEOUT-1
// -----------------------------------------------------------------------------
module dds_reg_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 13
) (
    input  logic             clk,
    input  logic             rst,
    dds_reg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         w_req;
    logic [1:0][7:0]    w_addr;
    logic [1:0][31:0]   w_din;
    logic               w_grant_vld;
    logic               w_grant_id;
    logic               w_timeout;
    logic [1:0]         w_gnt_onehot;

    logic               r_last;         // last-served port
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wr_start;
    logic [7:0]         r_wr_addr;
    logic [31:0]        r_wr_din;
    logic [1:0]         r_done;
    logic [1:0]         r_err;
    logic [31:0]        r_rdata;
    logic               r_busy;
    logic               r_gnt_id;

    assign w_req        = {bus.req1, bus.req0};
    assign w_addr       = {bus.addr1, bus.addr0};
    assign w_din        = {bus.din1, bus.din0};
    assign w_timeout    = (r_cnt == CNT_LAST);
    assign w_gnt_onehot = {r_gnt_id, ~r_gnt_id};

    // Round robin: on a tie the port that was not served last wins.
    always_comb begin
        w_grant_vld = |w_req;
        w_grant_id  = 1'b0;
        case (w_req)
            2'b01:   w_grant_id = 1'b0;
            2'b10:   w_grant_id = 1'b1;
            2'b11:   w_grant_id = ~r_last;
            default: w_grant_id = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            // wr_done has priority over the timeout, both exit WAIT
            S_WAIT:  if (bus.wr_done || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last     <= 1'b1;     // port 0 wins the first tie
            r_cnt      <= '0;
            r_wr_start <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_din   <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_gnt_id   <= 1'b0;
        end else begin
            // pulse outputs default low
            r_wr_start <= 1'b0;
            r_done     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_wr_addr  <= w_addr[w_grant_id];
                        r_wr_din   <= w_din[w_grant_id];
                        r_gnt_id   <= w_grant_id;
                        r_busy     <= 1'b1;
                        r_wr_start <= 1'b1;     // high during ISSUE
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (bus.wr_done) begin
                        r_rdata <= bus.wr_dout;
                        r_err   <= '0;
                        r_done  <= w_gnt_onehot;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= w_gnt_onehot;
                        r_done  <= w_gnt_onehot;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_last <= r_gnt_id;
                    r_err  <= '0;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.wr_start = r_wr_start;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_din   = r_wr_din;
    assign bus.done0    = r_done[0];
    assign bus.done1    = r_done[1];
    assign bus.err0     = r_err[0];
    assign bus.err1     = r_err[1];
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;
    assign bus.gnt_id   = r_gnt_id;
endmodule

// File: tb/tb_dds_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dds_reg_arbiter
// Scoreboard bench for dds_reg_arbiter. A wr_cmd responder predicts each
// transaction's outcome (granted port, err, rdata, done cycle) from the
// round-robin / timeout rules when it sees wr_start and queues it; a monitor
// pops and compares on every done pulse and checks rdata holds in between.
// -----------------------------------------------------------------------------
module tb_dds_reg_arbiter;
    localparam int TO = 8;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dds_reg_arbiter_if bus_if ();

    dds_reg_arbiter #(.TIMEOUT(TO), .CNT_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [1:0]  req_at_edge = 2'b00;
    logic        m_last = 1'b1;
    logic [31:0] m_rdata = 32'h0;
    int          fk = -1;           // forced wr_done delay; -1 random, -2 never
    logic [31:0] fdout = 32'h0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        req_at_edge <= {bus_if.req1, bus_if.req0};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // wr_cmd responder + reference model of the grant and outcome
    initial begin : responder
        logic        g;
        int          k;
        logic [31:0] d;
        exp_t        e;
        bus_if.wr_done = 1'b0;
        bus_if.wr_dout = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_last = 1'b1;
                exp_q.delete();
            end else if (bus_if.wr_start) begin
                chk("req_present", 64'(req_at_edge != 2'b00), 64'd1);
                if (req_at_edge == 2'b11) g = ~m_last;
                else                      g = req_at_edge[1];
                chk("gnt_id", 64'(bus_if.gnt_id), 64'(g));
                chk("busy_in_issue", 64'(bus_if.busy), 64'd1);
                chk("wr_addr", 64'(bus_if.wr_addr), 64'(g ? bus_if.addr1 : bus_if.addr0));
                chk("wr_din", 64'(bus_if.wr_din), 64'(g ? bus_if.din1 : bus_if.din0));
                m_last = g;
                if (fk >= 0)       k = fk;
                else if (fk == -2) k = -1;
                else begin
                    k = int'($urandom_range(0, TO + 2));
                    if (k == TO + 2) k = -1;
                end
                d = (fk >= 0) ? fdout : $urandom;
                if (k >= 0 && k <= TO - 1) e = '{g, 1'b0, d, cyc + k + 2};
                else                       e = '{g, 1'b1, 32'h0, cyc + TO + 1};
                exp_q.push_back(e);
                if (k >= 0) begin
                    repeat (k + 1) @(posedge clk);
                    #1 bus_if.wr_done = 1'b1; bus_if.wr_dout = d;
                    @(posedge clk);
                    #1 bus_if.wr_done = 1'b0; bus_if.wr_dout = $urandom;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) m_rdata = 32'h0;
            else if (bus_if.done0 || bus_if.done1) begin
                chk("single_done", 64'(bus_if.done0 & bus_if.done1), 64'd0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got done0=%0b done1=%0b, want no done", bus_if.done0, bus_if.done1);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_port", 64'(bus_if.done1), 64'(e.port));
                    chk("err", 64'(e.port ? bus_if.err1 : bus_if.err0), 64'(e.err));
                    chk("other_err", 64'(e.port ? bus_if.err0 : bus_if.err1), 64'd0);
                    chk("rdata", 64'(bus_if.rdata), 64'(e.rdata));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    m_rdata = e.rdata;
                end
            end else begin
                chk("rdata_hold", 64'(bus_if.rdata), 64'(m_rdata));
            end
        end
    end

    task automatic set_req(input int p, input logic v, input logic [7:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus_if.req0 = v;
            if (v) begin bus_if.addr0 = a; bus_if.din0 = d; end
        end else begin
            bus_if.req1 = v;
            if (v) begin bus_if.addr1 = a; bus_if.din1 = d; end
        end
    endtask

    task automatic wait_done(input int p, output int dc);
        int t;
        bit got;
        t = 0; got = 1'b0;
        while (!got && t < 200) begin
            @(negedge clk);
            t++;
            if ((p == 0 && bus_if.done0) || (p == 1 && bus_if.done1)) got = 1'b1;
        end
        dc = cyc;
        if (!got) begin
            n_chk++;
            $display("FAIL wait_done%0d: no done within 200 cycles, want one", p);
        end
    endtask

    task automatic wait_start(output int sc);
        int t;
        bit got;
        t = 0; got = 1'b0;
        while (!got && t < 200) begin
            @(negedge clk);
            t++;
            if (bus_if.wr_start) got = 1'b1;
        end
        sc = cyc;
        if (!got) begin
            n_chk++;
            $display("FAIL wait_start: no wr_start within 200 cycles, want one");
        end
    endtask

    task automatic run_port(input int p, input int n, input int maxgap);
        int dc;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
            @(posedge clk);
            #1 set_req(p, 1'b1, 8'($urandom), $urandom);
            wait_done(p, dc);
            @(posedge clk);
            #1 set_req(p, 1'b0, 8'h0, 32'h0);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c, ic, dc, t;
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
        bus_if.addr0 = 8'h0; bus_if.addr1 = 8'h0;
        bus_if.din0 = 32'h0; bus_if.din1 = 32'h0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_start", 64'(bus_if.wr_start), 64'd0);
        chk("rst_busy", 64'(bus_if.busy), 64'd0);
        chk("rst_done", 64'({bus_if.done1, bus_if.done0}), 64'd0);
        chk("rst_err", 64'({bus_if.err1, bus_if.err0}), 64'd0);
        chk("rst_rdata", 64'(bus_if.rdata), 64'd0);
        chk("rst_wr_addr", 64'(bus_if.wr_addr), 64'd0);
        chk("rst_wr_din", 64'(bus_if.wr_din), 64'd0);
        chk("rst_gnt_id", 64'(bus_if.gnt_id), 64'd0);
        @(negedge clk) rst = 1'b1;

        // reset in the middle of WAIT: no done, outputs back to idle
        fk = -2;
        @(posedge clk);
        #1 set_req(0, 1'b1, 8'h05, 32'h0000_0055);
        wait_start(ic);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_wr_start", 64'(bus_if.wr_start), 64'd0);
        chk("midrst_busy", 64'(bus_if.busy), 64'd0);
        chk("midrst_done", 64'({bus_if.done1, bus_if.done0}), 64'd0);
        set_req(0, 1'b0, 8'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // both requesting: first tie goes to port 0, then alternate
        fk = 3; fdout = 32'h0BAD_0001;
        fork
            run_port(0, 2, 0);
            run_port(1, 2, 0);
        join
        repeat (3) @(posedge clk);

        // single write: latency, captured address/data, one-cycle start
        fk = 6; fdout = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 set_req(0, 1'b1, 8'h01, 32'h1234_5678);
        c = cyc;
        wait_start(ic);
        chk("issue_latency", 64'(ic), 64'(c + 1));
        chk("t2_wr_addr", 64'(bus_if.wr_addr), 64'h01);
        chk("t2_wr_din", 64'(bus_if.wr_din), 64'h1234_5678);
        @(negedge clk);
        chk("start_one_cycle", 64'(bus_if.wr_start), 64'd0);
        chk("wr_din_stable", 64'(bus_if.wr_din), 64'h1234_5678);
        wait_done(0, dc);
        chk("t2_done_latency", 64'(dc), 64'(ic + 6 + 2));
        chk("t2_err0", 64'(bus_if.err0), 64'd0);
        @(posedge clk);
        #1 set_req(0, 1'b0, 8'h0, 32'h0);

        // port 1 read, result held afterwards
        fk = 4; fdout = 32'hCAFE_F00D;
        @(posedge clk);
        #1 set_req(1, 1'b1, 8'h81, 32'h0);
        wait_done(1, dc);
        chk("t4_rdata", 64'(bus_if.rdata), 64'hCAFE_F00D);
        @(posedge clk);
        #1 set_req(1, 1'b0, 8'h0, 32'h0);
        repeat (5) @(negedge clk);
        chk("t4_rdata_held", 64'(bus_if.rdata), 64'hCAFE_F00D);

        // timeout: no wr_done at all
        fk = -2;
        @(posedge clk);
        #1 set_req(0, 1'b1, 8'h02, 32'h0000_0002);
        wait_start(ic);
        wait_done(0, dc);
        chk("t5_timeout_latency", 64'(dc), 64'(ic + TO + 1));
        chk("t5_err0", 64'(bus_if.err0), 64'd1);
        chk("t5_rdata_zero", 64'(bus_if.rdata), 64'd0);
        @(posedge clk);
        #1 set_req(0, 1'b0, 8'h0, 32'h0);

        // wr_done on the final WAIT cycle still wins
        fk = TO - 1; fdout = 32'hA5A5_0001;
        @(posedge clk);
        #1 set_req(0, 1'b1, 8'h83, 32'h0);
        wait_done(0, dc);
        chk("t5_last_cycle_err0", 64'(bus_if.err0), 64'd0);
        chk("t5_last_cycle_rdata", 64'(bus_if.rdata), 64'hA5A5_0001);
        @(posedge clk);
        #1 set_req(0, 1'b0, 8'h0, 32'h0);

        // timeout followed by a stray wr_done landing in IDLE
        fk = TO + 1; fdout = 32'h5555_AAAA;
        @(posedge clk);
        #1 set_req(0, 1'b1, 8'h04, 32'h4);
        wait_done(0, dc);
        @(posedge clk);
        #1 set_req(0, 1'b0, 8'h0, 32'h0);
        repeat (4) @(negedge clk);
        chk("t6_stray_busy", 64'(bus_if.busy), 64'd0);

        // request dropped mid-WAIT still completes, and is not re-granted
        fk = 5; fdout = 32'h0F0F_0F0F;
        @(posedge clk);
        #1 set_req(0, 1'b1, 8'h86, 32'h0);
        wait_start(ic);
        @(posedge clk);
        #1 set_req(0, 1'b0, 8'h0, 32'h0);
        wait_done(0, dc);
        chk("t6_drop_rdata", 64'(bus_if.rdata), 64'h0F0F_0F0F);
        repeat (4) @(negedge clk);
        chk("t6_drop_busy", 64'(bus_if.busy), 64'd0);

        // random contention
        fk = -1;
        fork
            run_port(0, 20, 4);
            run_port(1, 20, 4);
        join

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
